compare_seq_ctrl: RTL

Sequential controller that compares two multi-digit unsigned operands using a single shared 2-bit comparator slice, one base-4 digit per clock, most-significant digit first. It stops early at the first unequal digit. It reports the result in the team's one-hot comparator encoding ({gt, eq, lt}: 100 a>b, 010 a==b, 001 a<b) through a start/busy/done handshake. It sits between the 2-bit comparator datapath and any block needing wide compares without replicating comparator logic.

---
 rtl/compare_seq_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/compare_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : compare_seq_ctrl
// Description : Wide unsigned magnitude compare built from one shared 2-bit
//               comparator slice. Operands are latched on an accepted start
//               and walked one base-4 digit per clock, most-significant
//               digit first, stopping at the first unequal digit.
//               Result is one-hot {gt, eq, lt}.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - request a compare (accepted only in IDLE)
//               a, b            - operands, sampled on the accepting edge
//               busy            - compare in progress
//               done            - one-cycle pulse, result valid
//               result          - {gt,eq,lt}; 000 until the first result
//               digits_used     - digits examined for the last result
// Revision    : 1.0 - initial release
// ============================================================================
module compare_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*DIGITS-1:0] a,
  input  logic [2*DIGITS-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [2:0]        result,
  output logic [CW-1:0]     digits_used
);

  localparam int W  = 2 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] C_GT = 3'b100;
  localparam logic [2:0] C_EQ = 3'b010;
  localparam logic [2:0] C_LT = 3'b001;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    ra, ra_nxt;
  logic [W-1:0]    rb, rb_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            busy_nxt;
  logic            done_nxt;
  logic [2:0]      result_nxt;
  logic [CW-1:0]   digits_used_nxt;

  logic [1:0]      dig_a;
  logic [1:0]      dig_b;
  logic [2:0]      slice;

  // Digit select: a mux over digit positions keeps the select width-clean
  // for any DIGITS.
  always_comb begin
    dig_a = 2'b00;
    dig_b = 2'b00;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        dig_a = ra[2*i +: 2];
        dig_b = rb[2*i +: 2];
      end
    end
  end

  // The shared 2-bit comparator slice.
  always_comb begin
    if (dig_a > dig_b) begin
      slice = C_GT;
    end else if (dig_a == dig_b) begin
      slice = C_EQ;
    end else begin
      slice = C_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ra          <= '0;
      rb          <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 3'b000;
      digits_used <= '0;
    end else begin
      state       <= state_nxt;
      ra          <= ra_nxt;
      rb          <= rb_nxt;
      idx         <= idx_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      result      <= result_nxt;
      digits_used <= digits_used_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ra_nxt          = ra;
    rb_nxt          = rb;
    idx_nxt         = idx;
    busy_nxt        = busy;
    // done is a pulse: it only survives the edge on which RUN finishes.
    done_nxt        = 1'b0;
    result_nxt      = result;
    digits_used_nxt = digits_used;

    unique case (state)
      IDLE: begin
        if (start) begin
          ra_nxt    = a;
          rb_nxt    = b;
          idx_nxt   = IW'(DIGITS - 1);
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is ignored here; nothing is queued.
        if ((slice != C_EQ) || (idx == '0)) begin
          result_nxt      = slice;
          digits_used_nxt = CW'(DIGITS) - CW'(idx);
          done_nxt        = 1'b1;
          busy_nxt        = 1'b0;
          state_nxt       = IDLE;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
